// File: rtl/br_feedback_unit_pkg.sv
// rtl/br_feedback_unit_pkg.sv - shared types, constants and state encodings for the branch feedback unit
package br_feedback_unit_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } fsm_state_t;

    typedef struct packed {
        addr_t pc;
        logic  taken;
    } fb_entry_t;

    // Fall-through PC wraps modulo 2^32 with the natural adder width.
    function automatic addr_t redirect_target(input addr_t pc, input addr_t target, input logic taken);
        return taken ? target : pc + addr_t'(4);
    endfunction

endpackage

// File: rtl/br_feedback_unit_fb_fifo.sv
// rtl/br_feedback_unit_fb_fifo.sv - circular FIFO of {pc, taken} BHT training entries
module br_feedback_unit_fb_fifo
    import br_feedback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  fb_entry_t i_entry,
    input  logic      i_pop,
    output fb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is forced to zero when empty so the unwritten storage never leaks out.
    assign o_head  = o_empty ? '0 : r_mem[r_head];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/br_feedback_unit.sv
// rtl/br_feedback_unit.sv - branch resolution: mispredict redirect, wrong-path drain and BHT feedback queue
module br_feedback_unit
    import br_feedback_unit_pkg::*;
#(
    parameter int FB_DEPTH  = 4,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rs_ena,
    output logic             rs_ready,
    input  logic             rs_is_br,
    input  logic [31:0]      rs_pc,
    input  logic             rs_taken_pred,
    input  logic             rs_taken_real,
    input  logic [31:0]      rs_target,
    input  logic             pd_ena,
    output logic             fb_ena,
    output logic             fb_taken_stat,
    output logic [31:0]      fb_pc,
    output logic             redirect_ena,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_miss
);

    localparam int DC_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    fsm_state_t      r_state;
    fsm_state_t      w_state_nxt;
    logic [DC_W-1:0] r_drain_cnt;
    logic [DC_W-1:0] w_drain_nxt;

    logic             r_redirect_ena;
    addr_t            r_redirect_pc;
    logic [CNT_W-1:0] r_cnt_br;
    logic [CNT_W-1:0] r_cnt_miss;

    logic      w_full;
    logic      w_empty;
    logic      w_accept;
    logic      w_miss;
    logic      w_push;
    logic      w_pop;
    fb_entry_t w_push_entry;
    fb_entry_t w_head;

    assign rs_ready     = (r_state == ST_IDLE) && !w_full;
    assign w_accept     = rs_ena && rs_ready;
    assign w_miss       = (rs_taken_real != rs_taken_pred);
    assign w_push       = w_accept && rs_is_br;
    assign w_pop        = !w_empty && pd_ena;
    assign w_push_entry = '{pc: rs_pc, taken: rs_taken_real};

    br_feedback_unit_fb_fifo #(
        .DEPTH (FB_DEPTH)
    ) u_fb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fb_ena        = !w_empty;
    assign fb_pc         = w_head.pc;
    assign fb_taken_stat = w_head.taken;

    // The redirect cycle counts as the first drain cycle, so the counter starts at DRAIN_CYC.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_miss) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DC_W'(DRAIN_CYC);
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt <= DC_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain_cnt - DC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_drain_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_drain_cnt    <= '0;
            r_redirect_ena <= FALSE;
            r_redirect_pc  <= ZERO_WORD;
            r_cnt_br       <= '0;
            r_cnt_miss     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_drain_cnt    <= w_drain_nxt;
            r_redirect_ena <= FALSE;
            if (w_accept && w_miss) begin
                r_redirect_ena <= TRUE;
                r_redirect_pc  <= redirect_target(rs_pc, rs_target, rs_taken_real);
                r_cnt_miss     <= r_cnt_miss + CNT_W'(1);
            end
            if (w_push) begin
                r_cnt_br <= r_cnt_br + CNT_W'(1);
            end
        end
    end

    assign redirect_ena = r_redirect_ena;
    assign redirect_pc  = r_redirect_pc;
    assign cnt_br       = r_cnt_br;
    assign cnt_miss     = r_cnt_miss;

endmodule

// File: tb/tb_br_feedback_unit.sv
// tb/tb_br_feedback_unit.sv - self-checking bench for br_feedback_unit
module tb_br_feedback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rs_ena;
    logic        rs_ready;
    logic        rs_is_br;
    logic [31:0] rs_pc;
    logic        rs_taken_pred;
    logic        rs_taken_real;
    logic [31:0] rs_target;
    logic        pd_ena;
    logic        fb_ena;
    logic        fb_taken_stat;
    logic [31:0] fb_pc;
    logic        redirect_ena;
    logic [31:0] redirect_pc;
    logic [31:0] cnt_br;
    logic [31:0] cnt_miss;

    br_feedback_unit #(
        .FB_DEPTH  (4),
        .DRAIN_CYC (2),
        .CNT_W     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs_ena        (rs_ena),
        .rs_ready      (rs_ready),
        .rs_is_br      (rs_is_br),
        .rs_pc         (rs_pc),
        .rs_taken_pred (rs_taken_pred),
        .rs_taken_real (rs_taken_real),
        .rs_target     (rs_target),
        .pd_ena        (pd_ena),
        .fb_ena        (fb_ena),
        .fb_taken_stat (fb_taken_stat),
        .fb_pc         (fb_pc),
        .redirect_ena  (redirect_ena),
        .redirect_pc   (redirect_pc),
        .cnt_br        (cnt_br),
        .cnt_miss      (cnt_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_br;
        logic [31:0] pc;
        logic        pred;
        logic        act;
        logic [31:0] tgt;
        logic        exp_rd;
        logic [31:0] exp_rpc;
        logic        probe;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } fb_exp_t;

    fb_exp_t     exp_fb_q[$];
    logic [31:0] exp_rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    int exp_br   = 0;
    int exp_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pops expectations whenever the DUT presents a redirect or a consumed feedback entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (redirect_ena === 1'b1) begin
                n_tests++;
                if (exp_rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL redirect_unexpected: got pc %h expected no redirect", redirect_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_rd_q.pop_front();
                    if (redirect_pc !== e) begin
                        n_fail++;
                        $display("FAIL redirect_pc: got %h expected %h", redirect_pc, e);
                    end
                end
            end
            if (fb_ena === 1'b1 && pd_ena === 1'b1) begin
                n_tests++;
                if (exp_fb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL fb_unexpected: got pc %h expected no entry", fb_pc);
                end else begin
                    fb_exp_t f;
                    f = exp_fb_q.pop_front();
                    if (fb_pc !== f.pc || fb_taken_stat !== f.taken) begin
                        n_fail++;
                        $display("FAIL fb_entry: got pc %h taken %b expected pc %h taken %b",
                                 fb_pc, fb_taken_stat, f.pc, f.taken);
                    end
                end
            end
        end
    end

    // Waits for rs_ready (bounded), presents one resolution for one accepting edge, returns at edge+1.
    task automatic resolve(input vec_t v);
        int guard;
        guard = 0;
        while (rs_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (rs_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got rs_ready %b expected 1", rs_ready);
        end
        rs_is_br      = v.is_br;
        rs_pc         = v.pc;
        rs_taken_pred = v.pred;
        rs_taken_real = v.act;
        rs_target     = v.tgt;
        rs_ena        = 1'b1;
        @(posedge clk);
        if (v.is_br) exp_fb_q.push_back('{pc: v.pc, taken: v.act});
        if (v.exp_rd) exp_rd_q.push_back(v.exp_rpc);
        #1;
        rs_ena = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        vecs[0] = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0180, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0204, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0500, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0600, 1'b1, 1'b1, 32'h0000_0700, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0610, 1'b0, 1'b1, 32'h0000_0900, 1'b1, 32'h0000_0900, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0000_0880, 1'b0, 32'h0, 1'b0};

        rst = 1'b1;
        rs_ena = 1'b0;
        rs_is_br = 1'b0;
        rs_pc = '0;
        rs_taken_pred = 1'b0;
        rs_taken_real = 1'b0;
        rs_target = '0;
        pd_ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        chk("reset_fb_ena", 32'(fb_ena), 32'd0);
        chk("reset_fb_pc", fb_pc, 32'd0);
        chk("reset_redirect_ena", 32'(redirect_ena), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_rs_ready", 32'(rs_ready), 32'd1);
        chk("reset_cnt_br", cnt_br, 32'd0);
        chk("reset_cnt_miss", cnt_miss, 32'd0);

        pd_ena = 1'b1;
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            exp_br   += int'(v.is_br);
            exp_miss += int'(v.exp_rd);
            resolve(v);
            chk($sformatf("v%0d_redirect_ena", i), 32'(redirect_ena), 32'(v.exp_rd));
            chk($sformatf("v%0d_fb_ena", i), 32'(fb_ena), 32'(v.is_br));
            if (v.is_br) chk($sformatf("v%0d_fb_pc", i), fb_pc, v.pc);
            if (v.probe) begin
                // Wrong-path resolutions presented during drain must be dropped.
                chk($sformatf("v%0d_drain_ready0", i), 32'(rs_ready), 32'd0);
                rs_is_br = 1'b1;
                rs_pc = 32'hDEAD_0000;
                rs_taken_pred = 1'b0;
                rs_taken_real = 1'b1;
                rs_ena = 1'b1;
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_drain_ready1", i), 32'(rs_ready), 32'd0);
                @(posedge clk);
                #1;
                rs_ena = 1'b0;
                chk($sformatf("v%0d_drain_done_ready", i), 32'(rs_ready), 32'd1);
                chk($sformatf("v%0d_drain_cnt_br", i), cnt_br, 32'(exp_br));
                chk($sformatf("v%0d_drain_cnt_miss", i), cnt_miss, 32'(exp_miss));
            end else begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_fb_popped", i), 32'(fb_ena), 32'd0);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("table_cnt_br", cnt_br, 32'(exp_br));
        chk("table_cnt_miss", cnt_miss, 32'(exp_miss));

        pd_ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = '{1'b1, 32'h0000_1000 + 32'(4 * k), k[0], k[0], 32'h0, 1'b0, 32'h0, 1'b0};
            exp_br++;
            resolve(v);
        end
        chk("full_rs_ready", 32'(rs_ready), 32'd0);
        chk("full_fb_pc", fb_pc, 32'h0000_1000);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_fb_pc", fb_pc, 32'h0000_1000);
        chk("hold_fb_ena", 32'(fb_ena), 32'd1);
        pd_ena = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_fb_empty", 32'(fb_ena), 32'd0);
        chk("drain_rs_ready", 32'(rs_ready), 32'd1);
        chk("fill_cnt_br", cnt_br, 32'(exp_br));

        pd_ena = 1'b0;
        resolve('{1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
        resolve('{1'b1, 32'h0000_2004, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0});
        resolve('{1'b1, 32'h0000_2008, 1'b1, 1'b0, 32'h0000_3000, 1'b1, 32'h0000_200C, 1'b0});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fb_q.delete();
        chk("rst_fb_ena", 32'(fb_ena), 32'd0);
        chk("rst_rs_ready", 32'(rs_ready), 32'd1);
        chk("rst_redirect_ena", 32'(redirect_ena), 32'd0);
        chk("rst_cnt_br", cnt_br, 32'd0);
        chk("rst_cnt_miss", cnt_miss, 32'd0);

        rs_is_br = 1'b1;
        rs_pc = 32'h0000_4000;
        rs_taken_pred = 1'b0;
        rs_taken_real = 1'b1;
        rs_target = 32'h0000_5000;
        rs_ena = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rs_ena = 1'b0;
        chk("rst_accept_redirect", 32'(redirect_ena), 32'd0);
        chk("rst_accept_fb_ena", 32'(fb_ena), 32'd0);
        chk("rst_accept_cnt_miss", cnt_miss, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        chk("rd_outstanding", 32'(exp_rd_q.size()), 32'd0);
        chk("fb_outstanding", 32'(exp_fb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
